// File: rtl/arb_pkg.sv
// Shared types and helpers for the unified-memory port arbiter.
// Grant encoding: owner 0 = CPU datapath, 1 = debug/program loader.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LDR = 1'b1;

  // Round-robin pick: a lone requester always wins; on contention the side
  // that did not hold the last grant goes next.
  function automatic logic pick_owner(input logic cpu_req,
                                      input logic ldr_req,
                                      input logic last_owner);
    logic pick;
    pick = OWN_CPU;
    if (cpu_req && ldr_req) begin
      pick = ~last_owner;
    end else if (ldr_req) begin
      pick = OWN_LDR;
    end
    return pick;
  endfunction

endpackage

// File: rtl/lat_counter.sv
// Loadable 4-bit down-counter that times the memory read latency.
// 'last' flags the final wait cycle (count == 1).
module lat_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] value,
  output logic       last
);

  logic [3:0] count;

  // Load wins over decrement; the count saturates at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 4'd0;
    end else if (load) begin
      count <= value;
    end else if (dec && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign last = (count == 4'd1);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the multicycle CPU's unified memory between the datapath and the
// loader port; one access in flight, IDLE->ISSUE->WAIT(LAT)->RESP. LAT: 1..15.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_stall,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic [DW-1:0] ldr_rdata,
  output logic          ldr_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          owner
);

  localparam logic [3:0] LAT_VAL = 4'(LAT);

  arb_state_t state;
  logic       gnt_we;
  logic       cnt_last;
  logic       next_owner;
  logic       cnt_load;
  logic       cnt_dec;

  assign next_owner = pick_owner(cpu_req, ldr_req, owner);
  assign cnt_load   = (state == ISSUE);
  assign cnt_dec    = (state == WAIT);

  lat_counter u_lat (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .value (LAT_VAL),
    .last  (cnt_last)
  );

  // Strobes and acks are registered on the transition into the state they
  // belong to, so they are high for exactly that state's cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OWN_LDR;
      gnt_we    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      ldr_rdata <= '0;
      cpu_ack   <= 1'b0;
      ldr_ack   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req || ldr_req) begin
            owner  <= next_owner;
            mem_en <= 1'b1;
            state  <= ISSUE;
            if (next_owner == OWN_LDR) begin
              gnt_we    <= ldr_we;
              mem_we    <= ldr_we;
              mem_addr  <= ldr_addr;
              mem_wdata <= ldr_wdata;
            end else begin
              gnt_we    <= cpu_we;
              mem_we    <= cpu_we;
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
            end
          end
        end
        ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          state  <= WAIT;
        end
        WAIT: begin
          // Memory data lands on the last wait cycle; writes leave rdata alone.
          if (cnt_last) begin
            if (owner == OWN_LDR) begin
              ldr_ack <= 1'b1;
              if (!gnt_we) ldr_rdata <= mem_rdata;
            end else begin
              cpu_ack <= 1'b1;
              if (!gnt_we) cpu_rdata <= mem_rdata;
            end
            state <= RESP;
          end
        end
        RESP: begin
          cpu_ack <= 1'b0;
          ldr_ack <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (LAT 2, 1, 15) on shared stimulus,
// each with its own fixed-latency read pipe over one shared memory array.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          cpu_req, cpu_we, ldr_req, ldr_we;
  logic [AW-1:0] cpu_addr, ldr_addr;
  logic [DW-1:0] cpu_wdata, ldr_wdata;

  logic [2:0][DW-1:0] cpuRdata, ldrRdata, memWdata;
  logic [2:0][AW-1:0] memAddr;
  logic [2:0]         cpuAck, cpuStall, ldrAck, memEn, memWe, owner;

  logic [31:0] mem [64];
  logic        loadEn;
  logic [5:0]  loadIdx;
  logic [31:0] loadData;

  // Only instance 0 is allowed to modify the shared memory.
  always @(posedge clk) begin
    if (loadEn) mem[loadIdx] <= loadData;
    else if (memEn[0] && memWe[0]) mem[memAddr[0][7:2]] <= memWdata[0];
  end

  for (genvar g = 0; g < 3; g++) begin : gDut
    localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 15;
    logic [31:0] pipe [1:15];
    logic [31:0] rdataIn;

    always @(posedge clk) begin
      pipe[1] <= memEn[g] ? mem[memAddr[g][7:2]] : 32'hBAD0_0000;
      for (int i = 2; i <= 15; i++) pipe[i] <= pipe[i-1];
    end
    assign rdataIn = pipe[L];

    mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(L)) dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpuRdata[g]),
      .cpu_ack   (cpuAck[g]),
      .cpu_stall (cpuStall[g]),
      .ldr_req   (ldr_req),
      .ldr_we    (ldr_we),
      .ldr_addr  (ldr_addr),
      .ldr_wdata (ldr_wdata),
      .ldr_rdata (ldrRdata[g]),
      .ldr_ack   (ldrAck[g]),
      .mem_en    (memEn[g]),
      .mem_we    (memWe[g]),
      .mem_addr  (memAddr[g]),
      .mem_wdata (memWdata[g]),
      .mem_rdata (rdataIn),
      .owner     (owner[g])
    );
  end

  typedef struct {
    string       name;
    logic        isLdr;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expCpuRdata;
    logic [31:0] expLdrRdata;
    logic        expOwner;
  } vec_t;

  vec_t vecs [7];
  int   passed = 0;
  int   total  = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  task automatic idleInputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0;
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One isolated transaction on instance 0; req held until ack, then dropped.
  task automatic applyStimulus(input vec_t v);
    int          ackCyc, enCnt, weCnt;
    logic        otherAck, myAck;
    logic [31:0] issueAddr, issueWdata;
    ackCyc = -1; enCnt = 0; weCnt = 0; otherAck = 1'b0;
    issueAddr = '0; issueWdata = '0;
    @(posedge clk); #1;
    if (v.isLdr) begin
      ldr_req = 1'b1; ldr_we = v.we; ldr_addr = v.addr; ldr_wdata = v.wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (memEn[0]) begin
        enCnt++;
        issueAddr  = memAddr[0];
        issueWdata = memWdata[0];
      end
      if (memWe[0]) weCnt++;
      myAck = v.isLdr ? ldrAck[0] : cpuAck[0];
      if (v.isLdr ? cpuAck[0] : ldrAck[0]) otherAck = 1'b1;
      if (!v.isLdr && k <= 4)
        checkOutput($sformatf("%s stall c%0d", v.name, k), 32'(cpuStall[0]), 32'(k < 4));
      if (myAck && ackCyc < 0) ackCyc = k;
      @(posedge clk); #1;
      if (ackCyc >= 0) idleInputs();
    end
    checkOutput({v.name, " ack cycle"}, 32'(ackCyc), 32'd4);
    checkOutput({v.name, " mem_en count"}, 32'(enCnt), 32'd1);
    checkOutput({v.name, " mem_we count"}, 32'(weCnt), 32'(v.we));
    checkOutput({v.name, " mem_addr"}, issueAddr, v.addr);
    if (v.we) checkOutput({v.name, " mem_wdata"}, issueWdata, v.wdata);
    checkOutput({v.name, " other ack"}, 32'(otherAck), 32'd0);
    checkOutput({v.name, " cpu_rdata"}, cpuRdata[0], v.expCpuRdata);
    checkOutput({v.name, " ldr_rdata"}, ldrRdata[0], v.expLdrRdata);
    checkOutput({v.name, " owner"}, 32'(owner[0]), 32'(v.expOwner));
  endtask

  initial begin
    int cpuAcks [2];
    int ldrAcks [2];
    int nc, nl, overlap, ackCyc;
    int firstAck [3];
    int ackCnt [3];
    int enCnt [3];

    vecs[0] = '{"cpu rd 10", 1'b0, 1'b0, 32'h10, 32'h0,         32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1] = '{"ldr wr 20", 1'b1, 1'b1, 32'h20, 32'h0000_1234, 32'hDEADBEEF, 32'h0,        1'b1};
    vecs[2] = '{"cpu rd 20", 1'b0, 1'b0, 32'h20, 32'h0,         32'h0000_1234, 32'h0,       1'b0};
    vecs[3] = '{"ldr rd 10", 1'b1, 1'b0, 32'h10, 32'h0,         32'h0000_1234, 32'hDEADBEEF, 1'b1};
    vecs[4] = '{"cpu wr 30", 1'b0, 1'b1, 32'h30, 32'h0000_55AA, 32'h0000_1234, 32'hDEADBEEF, 1'b0};
    vecs[5] = '{"ldr rd 30", 1'b1, 1'b0, 32'h30, 32'h0,         32'h0000_1234, 32'h0000_55AA, 1'b1};
    vecs[6] = '{"cpu rd 14", 1'b0, 1'b0, 32'h14, 32'h0,         32'hCAFEF00D, 32'h0000_55AA, 1'b0};

    idleInputs();
    rst = 1'b1;
    loadEn = 1'b1; loadIdx = 6'd4; loadData = 32'hDEADBEEF;
    @(posedge clk); #1;
    loadIdx = 6'd5; loadData = 32'hCAFEF00D;
    @(posedge clk); #1;
    loadEn = 1'b0;

    @(negedge clk);
    checkOutput("reset mem_en", 32'(memEn[0]), 32'd0);
    checkOutput("reset mem_we", 32'(memWe[0]), 32'd0);
    checkOutput("reset cpu_ack", 32'(cpuAck[0]), 32'd0);
    checkOutput("reset ldr_ack", 32'(ldrAck[0]), 32'd0);
    checkOutput("reset mem_addr", memAddr[0], 32'd0);
    checkOutput("reset cpu_rdata", cpuRdata[0], 32'd0);
    checkOutput("reset ldr_rdata", ldrRdata[0], 32'd0);
    checkOutput("reset owner", 32'(owner[0]), 32'd1);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

    // Contention: both held from cycle 0, CPU wins first.
    doReset();
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_addr = 32'h10;
    ldr_req = 1'b1; ldr_addr = 32'h14;
    nc = 0; nl = 0; overlap = 0;
    cpuAcks = '{-1, -1}; ldrAcks = '{-1, -1};
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      if (cpuAck[0] && ldrAck[0]) overlap++;
      if (cpuAck[0]) begin
        if (nc < 2) cpuAcks[nc] = k;
        nc++;
      end
      if (ldrAck[0]) begin
        if (nl < 2) ldrAcks[nl] = k;
        nl++;
      end
      @(posedge clk); #1;
      if (k == 19) idleInputs();
    end
    checkOutput("contend cpu ack count", 32'(nc), 32'd2);
    checkOutput("contend ldr ack count", 32'(nl), 32'd2);
    checkOutput("contend cpu ack 1", 32'(cpuAcks[0]), 32'd4);
    checkOutput("contend ldr ack 1", 32'(ldrAcks[0]), 32'd9);
    checkOutput("contend cpu ack 2", 32'(cpuAcks[1]), 32'd14);
    checkOutput("contend ldr ack 2", 32'(ldrAcks[1]), 32'd19);
    checkOutput("contend overlap", 32'(overlap), 32'd0);
    checkOutput("contend cpu_rdata", cpuRdata[0], 32'hDEADBEEF);
    checkOutput("contend ldr_rdata", ldrRdata[0], 32'hCAFEF00D);

    // Latency sweep with a one-cycle request pulse on all three instances.
    doReset();
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_addr = 32'h10;
    firstAck = '{-1, -1, -1}; ackCnt = '{0, 0, 0}; enCnt = '{0, 0, 0};
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        if (memEn[g]) enCnt[g]++;
        if (cpuAck[g]) begin
          ackCnt[g]++;
          if (firstAck[g] < 0) firstAck[g] = k;
        end
      end
      @(posedge clk); #1;
      if (k == 0) idleInputs();
    end
    checkOutput("sweep LAT2 ack cycle", 32'(firstAck[0]), 32'd4);
    checkOutput("sweep LAT1 ack cycle", 32'(firstAck[1]), 32'd3);
    checkOutput("sweep LAT15 ack cycle", 32'(firstAck[2]), 32'd17);
    for (int g = 0; g < 3; g++) begin
      checkOutput($sformatf("sweep inst%0d ack count", g), 32'(ackCnt[g]), 32'd1);
      checkOutput($sformatf("sweep inst%0d mem_en count", g), 32'(enCnt[g]), 32'd1);
      checkOutput($sformatf("sweep inst%0d cpu_rdata", g), cpuRdata[g], 32'hDEADBEEF);
    end

    // Reset asserted in WAIT (cycle 2) aborts the read.
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_addr = 32'h10;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("midreset cpu_ack", 32'(cpuAck[0]), 32'd0);
    checkOutput("midreset mem_en", 32'(memEn[0]), 32'd0);
    checkOutput("midreset mem_addr", memAddr[0], 32'd0);
    checkOutput("midreset cpu_rdata", cpuRdata[0], 32'd0);
    checkOutput("midreset owner", 32'(owner[0]), 32'd1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checkOutput($sformatf("midreset hold ack c%0d", k), 32'(cpuAck[0]), 32'd0);
    end
    @(posedge clk); #1 rst = 1'b0;
    ackCyc = -1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (cpuAck[0] && ackCyc < 0) ackCyc = k;
      @(posedge clk); #1;
      if (ackCyc >= 0) idleInputs();
    end
    checkOutput("post-reset ack cycle", 32'(ackCyc), 32'd4);
    checkOutput("post-reset cpu_rdata", cpuRdata[0], 32'hDEADBEEF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory of the multicycle processor between two requesters: the CPU datapath (fetch and load/store traffic) and a debug/program loader port.
- Sequences each access through a fixed-latency synchronous memory.
- Returns read data with a one-cycle acknowledge.
- Drives a stall flag that the control FSM uses to hold its current state until the memory access completes.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- LAT, 2, memory read latency in cycles after the mem_en cycle; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU access request; held high until cpu_ack.
- cpu_we  in  1  CPU write enable; 1 = store, 0 = fetch/load.
- cpu_addr  in  AW  CPU byte address, already selected by IorD.
- cpu_wdata  in  DW  CPU store data.
- cpu_rdata  out  DW  registered read data for the CPU.
- cpu_ack  out  1  one-cycle completion pulse to the CPU.
- cpu_stall  out  1  cpu_req & ~cpu_ack (combinational); holds the control FSM.
- ldr_req  in  1  loader access request.
- ldr_we  in  1  loader write enable.
- ldr_addr  in  AW  loader address.
- ldr_wdata  in  DW  loader write data.
- ldr_rdata  out  DW  registered read data for the loader.
- ldr_ack  out  1  one-cycle completion pulse to the loader.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write strobe.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid LAT cycles after mem_en.
- owner  out  1  current or last grant; 0 = CPU, 1 = loader.

Behaviour:
- Reset (async, rst=1), applied immediately:
  - state = IDLE.
  - mem_en, mem_we, cpu_ack, ldr_ack = 0.
  - mem_addr, mem_wdata, cpu_rdata, ldr_rdata = 0.
  - Latency counter = 0.
  - owner = 1, so the CPU wins the first contention.
- State machine states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Requests are sampled only in IDLE.
  - If exactly one req is high, grant it.
  - If both are high, grant the requester that is not equal to owner (round-robin).
  - On grant: latch addr/we/wdata, update owner, go to ISSUE.
  - If no req is high, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - mem_en = 1, mem_we = latched we; mem_addr/mem_wdata = latched values.
  - Load the counter with LAT; go to WAIT.
- WAIT:
  - mem_en = 0; decrement the counter each cycle.
  - On the cycle the counter equals 1, capture mem_rdata into the granted requester's rdata register and go to RESP.
  - WAIT lasts exactly LAT cycles.
- RESP (1 cycle):
  - Assert the granted requester's ack; the other ack stays 0. Go to IDLE.
- Latency:
  - If req is first sampled in IDLE in cycle 0, ack is high in cycle LAT+2 and rdata is valid from that cycle on.
  - Writes use identical timing.
  - Throughput: one access per LAT+3 cycles (RESP is followed by one IDLE cycle).
- rdata registers hold their value until the next read by the same requester.
- Writes do not update rdata.
- Only one access is ever outstanding; mem_en never asserts outside ISSUE.
- Requester rules:
  - A requester must keep req/addr/we/wdata stable until ack; the arbiter latches them in IDLE anyway.
  - If req drops mid-transaction, the access still completes and ack still pulses.
  - If req is still high in the IDLE cycle after ack, it is treated as a new request.
- Contention: with both requesters continuously requesting, grants alternate CPU, LDR, CPU, …
- Reset mid-transaction aborts the access: no ack is produced and there is no memory side effect beyond an already-issued mem_en.
- cpu_stall = cpu_req & ~cpu_ack, so it is low in the ack cycle and the control FSM advances on that edge.

Decomposition:
- Package arb_pkg holds:
  - state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3);
  - owner constants OWN_CPU=1'b0, OWN_LDR=1'b1.
- One sub-module, lat_counter: loadable 4-bit down-counter with load, dec and a last flag (count==1), instantiated once.

Test Plan:
- Single CPU read: LAT=2, memory preloaded with 0xDEADBEEF at 0x10; cpu_req, addr=0x10 in cycle 0 → mem_en in cycle 1 only; cpu_ack and cpu_rdata=0xDEADBEEF in cycle 4; cpu_stall is high in cycles 0–3 and low in cycle 4.
- Loader write then CPU read: ldr write 0x0000_1234 to 0x20 → ldr_ack in cycle 4, mem_we=1 only in ISSUE. Then CPU read of 0x20 → cpu_rdata=0x0000_1234.
- Contention: both reqs held high from cycle 0 → first grant CPU (owner=0); next grants LDR, CPU, LDR; acks at cycles 4, 9, 14, 19; the two acks never overlap.
- Latency sweep: LAT=1 and LAT=15 → ack at cycle 3 and cycle 17 respectively; exactly one mem_en per access.
- Reset in WAIT: assert rst in cycle 2 of a CPU read → all outputs 0 immediately, no ack; after release, a fresh CPU read completes normally.
- Req dropped early: cpu_req high only in cycle 0 → cpu_ack still pulses in cycle 4; no second access is issued.
